// File: rtl/mure_itype_classifier.sv
// Retired-instruction itype classifier with conditional-branch hold and a small in-order buffer.
// Optional feature macro: MURE_PULP_BRANCH_EN (classify P.BEQIMM / P.BNEIMM as branches).
module mure_itype_classifier #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITYPE_LEN  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [XLEN-1:0]      iaddr_i,
  input  logic [31:0]          inst_i,
  input  logic                 compressed_i,
  input  logic                 exception_i,
  input  logic                 interrupt_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ITYPE_LEN-1:0] itype_o,
  output logic [XLEN-1:0]      iaddr_o,
  output logic                 iretire_o,
  output logic [1:0]           ilastsize_o,
  output logic                 pending_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [ITYPE_LEN-1:0] {
    ItStd  = 'd0,
    ItExc  = 'd1,
    ItInt  = 'd2,
    ItEret = 'd3,
    ItNtb  = 'd4,
    ItTb   = 'd5,
    ItUj   = 'd6
  } itype_e;

  typedef struct packed {
    itype_e          itype;
    logic [XLEN-1:0] iaddr;
    logic            iretire;
    logic [1:0]      ilastsize;
  } entry_t;

  localparam logic [31:0] MatchMret   = 32'h3020_0073;
  localparam logic [31:0] MatchSret   = 32'h1020_0073;
  localparam logic [31:0] MatchUret   = 32'h0020_0073;
  localparam logic [31:0] MaskBr      = 32'h0000_707f;
  localparam logic [31:0] MatchBeq    = 32'h0000_0063;
  localparam logic [31:0] MatchBne    = 32'h0000_1063;
  localparam logic [31:0] MatchBlt    = 32'h0000_4063;
  localparam logic [31:0] MatchBge    = 32'h0000_5063;
  localparam logic [31:0] MatchBltu   = 32'h0000_6063;
  localparam logic [31:0] MatchBgeu   = 32'h0000_7063;
  localparam logic [31:0] MatchJalr   = 32'h0000_0067;
  localparam logic [31:0] MaskCBr     = 32'h0000_e003;
  localparam logic [31:0] MatchCBeqz  = 32'h0000_c001;
  localparam logic [31:0] MatchCBnez  = 32'h0000_e001;
  localparam logic [31:0] MaskCJr     = 32'h0000_f07f;
  localparam logic [31:0] MatchCJr    = 32'h0000_8002;
  localparam logic [31:0] MatchCJalr  = 32'h0000_9002;
`ifdef MURE_PULP_BRANCH_EN
  localparam logic [31:0] MatchPBeqimm = 32'h0000_2063;
  localparam logic [31:0] MatchPBneimm = 32'h0000_3063;
`endif

  entry_t          r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_pend;
  logic [XLEN-1:0] r_br_addr;
  logic            r_br_c;

  logic            w_eret, w_br, w_br_pulp, w_uj, w_hold;
  itype_e          w_itype;
  logic            w_accept, w_pop;
  logic [XLEN-1:0] w_next_seq;
  entry_t          w_res, w_cur, w_ent0, w_ent1, w_head;
  logic [1:0]      w_push_n;
  logic [PtrW-1:0] w_wr_ptr_d, w_rd_ptr_d;
  logic [CntW-1:0] w_count_d;
  logic            w_pend_d, w_br_c_d;
  logic [XLEN-1:0] w_br_addr_d;

  // Instruction decode; compressed and 32-bit patterns are mutually gated by compressed_i.
  always_comb begin
    w_eret = ~compressed_i &
             ((inst_i == MatchMret) | (inst_i == MatchSret) | (inst_i == MatchUret));
    w_br   = (~compressed_i & (((inst_i & MaskBr) == MatchBeq)  |
                               ((inst_i & MaskBr) == MatchBne)  |
                               ((inst_i & MaskBr) == MatchBlt)  |
                               ((inst_i & MaskBr) == MatchBge)  |
                               ((inst_i & MaskBr) == MatchBltu) |
                               ((inst_i & MaskBr) == MatchBgeu))) |
             (compressed_i & (((inst_i & MaskCBr) == MatchCBeqz) |
                              ((inst_i & MaskCBr) == MatchCBnez)));
`ifdef MURE_PULP_BRANCH_EN
    w_br_pulp = ~compressed_i & (((inst_i & MaskBr) == MatchPBeqimm) |
                                 ((inst_i & MaskBr) == MatchPBneimm));
`else
    w_br_pulp = 1'b0;
`endif
    w_uj   = (~compressed_i & ((inst_i & MaskBr) == MatchJalr)) |
             (compressed_i & (inst_i[11:7] != 5'd0) &
              (((inst_i & MaskCJr) == MatchCJr) | ((inst_i & MaskCJr) == MatchCJalr)));

    w_itype = ItStd;
    if (exception_i)      w_itype = ItExc;
    else if (interrupt_i) w_itype = ItInt;
    else if (w_eret)      w_itype = ItEret;
    else if (w_uj)        w_itype = ItUj;

    w_hold = ~exception_i & ~interrupt_i & ~w_eret & (w_br | w_br_pulp);
  end

  always_comb begin
    w_accept   = valid_i & ready_o & ~flush_i;
    w_pop      = (r_count != '0) & ready_i & ~flush_i;
    w_next_seq = r_br_addr + (r_br_c ? XLEN'(2) : XLEN'(4));

    w_res.itype     = (iaddr_i != w_next_seq) ? ItTb : ItNtb;
    w_res.iaddr     = r_br_addr;
    w_res.iretire   = 1'b1;
    w_res.ilastsize = {1'b0, ~r_br_c};

    w_cur.itype     = w_itype;
    w_cur.iaddr     = iaddr_i;
    w_cur.iretire   = ~exception_i;
    w_cur.ilastsize = {1'b0, ~compressed_i};

    w_ent0      = w_cur;
    w_ent1      = w_cur;
    w_push_n    = 2'd0;
    w_pend_d    = r_pend;
    w_br_addr_d = r_br_addr;
    w_br_c_d    = r_br_c;

    if (flush_i) begin
      w_pend_d = 1'b0;
    end else if (w_accept) begin
      // A held branch always drains ahead of whatever resolved it.
      if (r_pend) begin
        w_ent0   = w_res;
        w_push_n = w_hold ? 2'd1 : 2'd2;
      end else begin
        w_push_n = w_hold ? 2'd0 : 2'd1;
      end
      w_pend_d = w_hold;
      if (w_hold) begin
        w_br_addr_d = iaddr_i;
        w_br_c_d    = compressed_i;
      end
    end

    if (flush_i) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      w_wr_ptr_d = r_wr_ptr + PtrW'(w_push_n);
      w_rd_ptr_d = r_rd_ptr + PtrW'(w_pop);
      w_count_d  = r_count + CntW'(w_push_n) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pend    <= 1'b0;
      r_br_addr <= '0;
      r_br_c    <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_d;
      r_rd_ptr  <= w_rd_ptr_d;
      r_count   <= w_count_d;
      r_pend    <= w_pend_d;
      r_br_addr <= w_br_addr_d;
      r_br_c    <= w_br_c_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      if (w_push_n != 2'd0) r_mem[r_wr_ptr] <= w_ent0;
      if (w_push_n == 2'd2) r_mem[r_wr_ptr + PtrW'(1)] <= w_ent1;
    end
  end

  // Data outputs are forced to zero while empty so reset state is clean.
  always_comb begin
    w_head      = r_mem[r_rd_ptr];
    valid_o     = (r_count != '0);
    ready_o     = (r_count <= CntW'(FIFO_DEPTH - 2));
    pending_o   = r_pend;
    itype_o     = valid_o ? w_head.itype : '0;
    iaddr_o     = valid_o ? w_head.iaddr : '0;
    iretire_o   = valid_o & w_head.iretire;
    ilastsize_o = valid_o ? w_head.ilastsize : 2'd0;
  end

endmodule

// File: tb/tb_mure_itype_classifier.sv
// Randomized self-checking bench for mure_itype_classifier against a queue-based reference model.
module tb_mure_itype_classifier;

  localparam int XLEN = 32;
  localparam longint unsigned AddrMask = 64'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0, ready_o;
  logic [XLEN-1:0] iaddr_i = '0;
  logic [31:0]     inst_i = '0;
  logic            compressed_i = 1'b0, exception_i = 1'b0, interrupt_i = 1'b0, flush_i = 1'b0;
  logic            valid_o, ready_i = 1'b0, iretire_o, pending_o;
  logic [2:0]      itype_o;
  logic [XLEN-1:0] iaddr_o;
  logic [1:0]      ilastsize_o;

  always #5 clk = ~clk;

  mure_itype_classifier #(.FIFO_DEPTH(4), .XLEN(XLEN), .ITYPE_LEN(3)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .iaddr_i     (iaddr_i),
    .inst_i      (inst_i),
    .compressed_i(compressed_i),
    .exception_i (exception_i),
    .interrupt_i (interrupt_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .itype_o     (itype_o),
    .iaddr_o     (iaddr_o),
    .iretire_o   (iretire_o),
    .ilastsize_o (ilastsize_o),
    .pending_o   (pending_o)
  );

  typedef struct {
    int              itype;
    longint unsigned addr;
    int              retire;
    int              size;
  } ent_t;

  ent_t            q[$];
  bit              m_pend;
  longint unsigned m_baddr;
  bit              m_bc;
  int              errors = 0;
  int              checks = 0;
  longint unsigned last_addr = 0;
  bit              last_c = 1'b0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode by instruction fields, not mask tables.
  function automatic bit is_branch(logic [31:0] inst, bit c);
    if (c) return (inst[1:0] == 2'b01) && (inst[15:14] == 2'b11);
`ifdef MURE_PULP_BRANCH_EN
    return inst[6:0] == 7'h63;
`else
    return (inst[6:0] == 7'h63) && (inst[14:12] != 3'd2) && (inst[14:12] != 3'd3);
`endif
  endfunction

  function automatic int base_class(logic [31:0] inst, bit c);
    if (!c && (inst == 32'h3020_0073 || inst == 32'h1020_0073 || inst == 32'h0020_0073))
      return 3;
    if (!c && inst[6:0] == 7'h67 && inst[14:12] == 3'd0) return 6;
    if (c && inst[1:0] == 2'b10 && inst[15:13] == 3'b100 && inst[6:2] == 5'd0 &&
        inst[11:7] != 5'd0) return 6;
    return 0;
  endfunction

  task automatic check_outputs();
    check_eq("valid_o", valid_o, q.size() != 0);
    check_eq("ready_o", ready_o, q.size() <= 2);
    check_eq("pending_o", pending_o, m_pend);
    if (q.size() != 0) begin
      check_eq("itype_o", itype_o, q[0].itype);
      check_eq("iaddr_o", iaddr_o, q[0].addr);
      check_eq("iretire_o", iretire_o, q[0].retire);
      check_eq("ilastsize_o", ilastsize_o, q[0].size);
    end else begin
      check_eq("itype_o_idle", itype_o, 0);
      check_eq("iaddr_o_idle", iaddr_o, 0);
    end
  endtask

  task automatic step(bit rst, bit v, logic [31:0] inst, longint unsigned addr, bit c, bit exc,
                      bit irq, bit fl, bit rdy);
    bit              acc;
    bit              hold;
    ent_t            cur;
    ent_t            res;
    longint unsigned a;
    longint unsigned nxt;
    @(negedge clk);
    if (rst_n) check_outputs();
    rst_n = rst; valid_i = v; inst_i = inst; iaddr_i = addr[XLEN-1:0]; compressed_i = c;
    exception_i = exc; interrupt_i = irq; flush_i = fl; ready_i = rdy;
    if (v) begin last_addr = addr; last_c = c; end
    if (!rst || fl) begin
      q.delete();
      m_pend = 1'b0;
      return;
    end
    a   = addr & AddrMask;
    acc = v && (q.size() <= 2);
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (acc) begin
      hold       = !exc && !irq && is_branch(inst, c);
      cur.itype  = exc ? 1 : (irq ? 2 : base_class(inst, c));
      cur.addr   = a;
      cur.retire = exc ? 0 : 1;
      cur.size   = c ? 0 : 1;
      if (m_pend) begin
        nxt        = (m_baddr + (m_bc ? 2 : 4)) & AddrMask;
        res.itype  = (a != nxt) ? 5 : 4;
        res.addr   = m_baddr;
        res.retire = 1;
        res.size   = m_bc ? 0 : 1;
        q.push_back(res);
      end
      if (hold) begin
        m_pend = 1'b1; m_baddr = a; m_bc = c;
      end else begin
        m_pend = 1'b0;
        q.push_back(cur);
      end
    end
  endtask

  task automatic idle(bit rdy);
    step(1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic put(logic [31:0] inst, longint unsigned addr, bit c, bit rdy);
    step(1'b1, 1'b1, inst, addr, c, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic rand_step();
    logic [31:0]     inst;
    bit              c;
    longint unsigned addr;
    c = 1'b0;
    case ($urandom_range(0, 7))
      0: inst = ($urandom & 32'hFFFF_FF80) | 32'h13;
      1: inst = ($urandom & 32'hFFFF_FF80) | 32'h63;
      2: inst = ($urandom & 32'hFFFF_8F80) | 32'h67;
      3: case ($urandom_range(0, 2))
           0: inst = 32'h3020_0073;
           1: inst = 32'h1020_0073;
           default: inst = 32'h0020_0073;
         endcase
      4: begin inst = ($urandom & 32'hFFFF_3FFC) | 32'hC001; c = 1'b1; end
      5: begin inst = ($urandom & 32'hFFFF_1F80) | 32'h8002; c = 1'b1; end
      6: inst = $urandom;
      default: begin inst = $urandom; c = 1'b1; end
    endcase
    if ($urandom_range(0, 1) == 1) addr = (last_addr + (last_c ? 2 : 4)) & AddrMask;
    else addr = {32'h0, $urandom & 32'hFFFF_FFFE};
    step(1'b1, $urandom_range(0, 3) != 0, inst, addr, c, $urandom_range(0, 9) == 0,
         $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
  endtask

  initial begin
    m_pend = 1'b0; m_baddr = 0; m_bc = 1'b0;
    step(1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    // Explicit reset-state checks.
    @(negedge clk);
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_ready_o", ready_o, 1);
    check_eq("rst_pending_o", pending_o, 0);
    check_eq("rst_iaddr_o", iaddr_o, 0);
    idle(1'b1);
    // Plain STD.
    put(32'h0640_0093, 64'h100, 1'b0, 1'b1); idle(1'b1); idle(1'b1);
    // BEQ not taken, then C.BNEZ taken, then wrap-around NTB.
    put(32'h0020_8463, 64'h200, 1'b0, 1'b1); put(32'h0010_0093, 64'h204, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    put(32'h0000_E401, 64'h300, 1'b1, 1'b1); put(32'h0010_0093, 64'h340, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    put(32'h0020_8463, 64'hFFFF_FFFC, 1'b0, 1'b1); put(32'h0010_0093, 64'h0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1); idle(1'b1);
    // Backpressure: the fourth retirement must be dropped.
    for (int i = 0; i < 4; i++) put(32'h0010_0093, 64'h400 + 4 * i, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    // Exception on a branch, returns and jumps.
    step(1'b1, 1'b1, 32'h0020_8463, 64'h500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    put(32'h3020_0073, 64'h504, 1'b0, 1'b1);
    put(32'h0000_8082, 64'h508, 1'b1, 1'b1);
    put(32'h0000_8067, 64'h50A, 1'b0, 1'b1);
    put(32'h0000_8002, 64'h50E, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);
    // Flush with a held branch and two buffered entries.
    put(32'h0010_0093, 64'h5F0, 1'b0, 1'b0); put(32'h0010_0093, 64'h5F4, 1'b0, 1'b0);
    put(32'h0020_8463, 64'h600, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0010_0093, 64'h604, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1); idle(1'b1);
    // P.BEQIMM / P.BNEIMM encodings.
    put(32'h0050_2063, 64'h700, 1'b0, 1'b1); put(32'h0010_0093, 64'h800, 1'b0, 1'b1);
    put(32'h0050_3063, 64'h804, 1'b0, 1'b1); put(32'h0010_0093, 64'h808, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    for (int i = 0; i < 3000; i++) rand_step();
    // Reset in the middle of traffic.
    step(1'b0, 1'b1, 32'h0010_0093, 64'h900, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 1000; i++) rand_step();
    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
